// File: rtl/uio_bus_arbiter_if.sv
// Bundle of the uio pad bus, requester handshake and read-back signals shared
// between the requesters (master side) and the arbiter (slave side).
interface uio_bus_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    logic                ena;
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     dir;
    logic [NREQ*8-1:0]   wdata;
    logic [7:0]          uio_in;
    logic [7:0]          uio_out;
    logic [7:0]          uio_oe;
    logic [NREQ-1:0]     gnt;
    logic [7:0]          rdata;
    logic                rvalid;
    logic                busy;

    modport master (
        output ena, req, dir, wdata, uio_in,
        input  uio_out, uio_oe, gnt, rdata, rvalid, busy
    );

    modport slave (
        input  ena, req, dir, wdata, uio_in,
        output uio_out, uio_oe, gnt, rdata, rvalid, busy
    );
endinterface

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the 8-bit uio pad bus: one requester at a time drives
// or samples the pads, with a parked cycle between consecutive owners.
module uio_bus_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    uio_bus_arbiter_if.slave bus
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   ptr;
    logic            odir;
    logic [HW-1:0]   hcnt;
    logic [NREQ-1:0] gnt;
    logic [7:0]      rdata;
    logic            rvalid;
    logic            busy;

    logic            win_valid_c;
    logic [PW-1:0]   win_idx_c;
    logic [PW-1:0]   cand_c;
    logic            release_c;
    logic            drive_c;
    logic [7:0]      pad_out_c;

    // First requester at or after ptr+1, wrapping; lowest offset wins.
    always_comb begin
        win_valid_c = 1'b0;
        win_idx_c   = '0;
        cand_c      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand_c = PW'((32'(ptr) + k) % NREQ);
            if (!win_valid_c && bus.req[cand_c]) begin
                win_valid_c = 1'b1;
                win_idx_c   = cand_c;
            end
        end
    end

    // Owner gives up the bus on request drop or once its hold budget is spent.
    always_comb begin
        release_c = (hcnt == HW'(MAX_HOLD)) || !bus.req[owner];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= '0;
            odir   <= 1'b0;
            ptr    <= PW'(NREQ - 1);
            hcnt   <= '0;
            gnt    <= '0;
            busy   <= 1'b0;
            rdata  <= 8'h00;
            rvalid <= 1'b0;
        end else begin
            // Read-back follows the registered ownership of the cycle just ended.
            if (state == OWN && !odir) begin
                rdata  <= bus.uio_in;
                rvalid <= 1'b1;
            end else begin
                rvalid <= 1'b0;
            end

            if (!bus.ena) begin
                state <= IDLE;
                gnt   <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE, TURN: begin
                        if (win_valid_c) begin
                            state <= OWN;
                            owner <= win_idx_c;
                            ptr   <= win_idx_c;
                            odir  <= bus.dir[win_idx_c];
                            hcnt  <= HW'(1);
                            gnt   <= NREQ'(1) << win_idx_c;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                            gnt   <= '0;
                            busy  <= 1'b0;
                        end
                    end
                    OWN: begin
                        if (hcnt != HW'(MAX_HOLD)) begin
                            hcnt <= hcnt + HW'(1);
                        end
                        if (release_c) begin
                            state <= TURN;
                            gnt   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Pads are driven only by a write-mode owner; data passes through live.
    always_comb begin
        drive_c   = (state == OWN) && odir;
        pad_out_c = 8'h00;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (drive_c && owner == PW'(i)) begin
                pad_out_c = bus.wdata[8*i +: 8];
            end
        end
    end

    assign bus.uio_oe  = drive_c ? 8'hFF : 8'h00;
    assign bus.uio_out = pad_out_c;
    assign bus.gnt     = gnt;
    assign bus.busy    = busy;
    assign bus.rdata   = rdata;
    assign bus.rvalid  = rvalid;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Scoreboard bench for uio_bus_arbiter: directed scenarios plus random traffic
// checked every cycle against a behavioural ownership model.
module tb_uio_bus_arbiter;
    localparam int NREQ     = 4;
    localparam int MAX_HOLD = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uio_bus_arbiter_if #(.NREQ(NREQ)) bus ();

    uio_bus_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0] gnt;
        logic [7:0] oe;
        logic [7:0] out;
        logic [7:0] rdata;
        logic       rvalid;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];

    // Model: who owns the bus, for how many cycles so far, and who went last.
    int         m_owner  = -1;
    bit         m_turn   = 1'b0;
    int         m_ptr    = NREQ - 1;
    int         m_held   = 0;
    bit         m_odir   = 1'b0;
    bit         m_rvalid = 1'b0;
    logic [7:0] m_rdata  = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step();
        exp_t e;
        if (rst) begin
            m_owner  = -1;
            m_turn   = 1'b0;
            m_ptr    = NREQ - 1;
            m_held   = 0;
            m_rvalid = 1'b0;
            m_rdata  = 8'h00;
        end else begin
            if (m_owner >= 0 && !m_odir) begin
                m_rvalid = 1'b1;
                m_rdata  = bus.uio_in;
            end else begin
                m_rvalid = 1'b0;
            end
            if (!bus.ena) begin
                m_owner = -1;
                m_turn  = 1'b0;
            end else if (m_owner >= 0) begin
                if (!bus.req[m_owner] || m_held == MAX_HOLD) begin
                    m_owner = -1;
                    m_turn  = 1'b1;
                end else begin
                    m_held++;
                end
            end else begin
                m_turn = 1'b0;
                for (int k = 1; k <= NREQ; k++) begin
                    int c = (m_ptr + k) % NREQ;
                    if (bus.req[c]) begin
                        m_owner = c;
                        m_ptr   = c;
                        m_odir  = bus.dir[c];
                        m_held  = 1;
                        break;
                    end
                end
            end
        end
        e.gnt    = (m_owner >= 0) ? 4'(1 << m_owner) : 4'h0;
        e.oe     = (m_owner >= 0 && m_odir) ? 8'hFF : 8'h00;
        e.out    = (m_owner >= 0 && m_odir) ? bus.wdata[8*m_owner +: 8] : 8'h00;
        e.rdata  = m_rdata;
        e.rvalid = m_rvalid;
        e.busy   = (m_owner >= 0) || m_turn;
        exp_q.push_back(e);
    endfunction

    // Apply one cycle of inputs away from the edge and record the expectation.
    task automatic cyc(input bit r, input bit en, input logic [3:0] rq, input logic [3:0] dr,
                       input logic [31:0] wd, input logic [7:0] ui);
        @(negedge clk);
        rst        = r;
        bus.ena    = en;
        bus.req    = rq;
        bus.dir    = dr;
        bus.wdata  = wd;
        bus.uio_in = ui;
        model_step();
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every edge that has an expectation pending is compared in full.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("gnt",     32'(bus.gnt),     32'(e.gnt));
                chk("uio_oe",  32'(bus.uio_oe),  32'(e.oe));
                chk("uio_out", 32'(bus.uio_out), 32'(e.out));
                chk("rdata",   32'(bus.rdata),   32'(e.rdata));
                chk("rvalid",  32'(bus.rvalid),  32'(e.rvalid));
                chk("busy",    32'(bus.busy),    32'(e.busy));
                chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
            end
        end
    end

    initial begin
        logic [3:0] rq;
        logic [3:0] prev_gnt;
        logic [3:0] seq[$];
        logic [3:0] exp_seq[5];

        rst        = 1'b1;
        bus.ena    = 1'b0;
        bus.req    = '0;
        bus.dir    = '0;
        bus.wdata  = '0;
        bus.uio_in = '0;

        // Reset with random inputs
        repeat (2) cyc(1'b1, 1'($urandom()), 4'($urandom()), 4'($urandom()), $urandom(), 8'($urandom()));
        after_edge();
        chk("rst_gnt",    32'(bus.gnt),    32'd0);
        chk("rst_oe",     32'(bus.uio_oe), 32'd0);
        chk("rst_out",    32'(bus.uio_out), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_rdata",  32'(bus.rdata),  32'd0);
        chk("rst_busy",   32'(bus.busy),   32'd0);
        cyc(1'b0, 1'b1, 4'b1111, 4'($urandom()), $urandom(), 8'($urandom()));
        after_edge();
        chk("first_grant", 32'(bus.gnt), 32'b0001);
        repeat (3) cyc(1'b0, 1'b1, 4'b0000, 4'b0000, 32'h0, 8'h00);

        // Single write, held past MAX_HOLD
        for (int i = 1; i <= 12; i++) begin
            cyc(1'b0, 1'b1, 4'b0010, 4'b0010, 32'h0000_A500, 8'($urandom()));
            after_edge();
            if (i <= MAX_HOLD) begin
                chk("wr_gnt", 32'(bus.gnt), 32'b0010);
                chk("wr_oe",  32'(bus.uio_oe), 32'hFF);
                chk("wr_out", 32'(bus.uio_out), 32'hA5);
            end else if (i == MAX_HOLD + 1) begin
                chk("wr_turn_gnt", 32'(bus.gnt), 32'd0);
                chk("wr_turn_oe",  32'(bus.uio_oe), 32'd0);
            end else begin
                chk("wr_regrant", 32'(bus.gnt), 32'b0010);
            end
        end
        repeat (3) cyc(1'b0, 1'b1, 4'b0000, 4'b0000, 32'h0, 8'h00);

        // Round-robin between 0 and 2 with 3-cycle grants
        cyc(1'b1, 1'b1, 4'b0000, 4'b0000, 32'h0, 8'h00);
        prev_gnt = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            rq = 4'b0101;
            if (m_owner >= 0 && m_held == 3) rq[m_owner] = 1'b0;
            cyc(1'b0, 1'b1, rq, 4'($urandom()), $urandom(), 8'($urandom()));
            after_edge();
            if (bus.gnt != prev_gnt) seq.push_back(bus.gnt);
            prev_gnt = bus.gnt;
        end
        exp_seq = '{4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b0001};
        chk("rr_seq_len", 32'(seq.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i < seq.size()) chk("rr_seq", 32'(seq[i]), 32'(exp_seq[i]));
        end
        repeat (3) cyc(1'b0, 1'b1, 4'b0000, 4'b0000, 32'h0, 8'h00);

        // Read: two owned cycles sampling 3C then C3
        cyc(1'b0, 1'b1, 4'b1000, 4'b0000, $urandom(), 8'h00);
        after_edge();
        chk("rd_gnt", 32'(bus.gnt), 32'b1000);
        chk("rd_oe",  32'(bus.uio_oe), 32'd0);
        cyc(1'b0, 1'b1, 4'b1000, 4'b0000, $urandom(), 8'h3C);
        after_edge();
        chk("rd_rvalid1", 32'(bus.rvalid), 32'd1);
        chk("rd_rdata1",  32'(bus.rdata),  32'h3C);
        chk("rd_oe1",     32'(bus.uio_oe), 32'd0);
        cyc(1'b0, 1'b1, 4'b0000, 4'b0000, $urandom(), 8'hC3);
        after_edge();
        chk("rd_rvalid2", 32'(bus.rvalid), 32'd1);
        chk("rd_rdata2",  32'(bus.rdata),  32'hC3);
        cyc(1'b0, 1'b1, 4'b0000, 4'b0000, $urandom(), 8'h55);
        after_edge();
        chk("rd_rvalid_end", 32'(bus.rvalid), 32'd0);
        chk("rd_rdata_hold", 32'(bus.rdata),  32'hC3);
        cyc(1'b0, 1'b1, 4'b0000, 4'b0000, 32'h0, 8'h00);

        // dir flips mid-grant must not release the pads
        cyc(1'b0, 1'b1, 4'b0010, 4'b0010, $urandom(), 8'($urandom()));
        after_edge();
        chk("dir_oe0", 32'(bus.uio_oe), 32'hFF);
        repeat (3) begin
            cyc(1'b0, 1'b1, 4'b0010, 4'b0000, $urandom(), 8'($urandom()));
            after_edge();
            chk("dir_oe_held", 32'(bus.uio_oe), 32'hFF);
        end

        // ena drop mid-grant
        repeat (3) begin
            cyc(1'b0, 1'b0, 4'b0010, 4'b0010, $urandom(), 8'($urandom()));
            after_edge();
            chk("ena_gnt",  32'(bus.gnt),    32'd0);
            chk("ena_oe",   32'(bus.uio_oe), 32'd0);
            chk("ena_busy", 32'(bus.busy),   32'd0);
        end
        cyc(1'b0, 1'b1, 4'b0010, 4'b0010, $urandom(), 8'($urandom()));
        after_edge();
        chk("ena_back_gnt", 32'(bus.gnt), 32'b0010);

        // Reset while driving
        cyc(1'b0, 1'b1, 4'b0010, 4'b0010, $urandom(), 8'($urandom()));
        cyc(1'b1, 1'b1, 4'b0101, 4'b0101, $urandom(), 8'($urandom()));
        after_edge();
        chk("rst_own_oe",  32'(bus.uio_oe), 32'd0);
        chk("rst_own_gnt", 32'(bus.gnt),    32'd0);
        cyc(1'b0, 1'b1, 4'b0101, 4'b0101, $urandom(), 8'($urandom()));
        after_edge();
        chk("rst_own_ptr", 32'(bus.gnt), 32'b0001);

        // Random traffic with sticky requests
        rq = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            rq = rq ^ (4'($urandom()) & 4'($urandom()) & 4'($urandom()));
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 15) != 0), rq,
                4'($urandom()), $urandom(), 8'($urandom()));
        end

        repeat (2) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uio_bus_arbiter.md
# uio_bus_arbiter

Round-robin arbiter that shares the 8-bit bidirectional `uio` pad bus among `NREQ` internal requesters inside the tile's top-level user design.
- Each grant gives one requester exclusive ownership of the bus, in either drive (write) or sample (read) mode, for a bounded number of cycles.
- The block owns `uio_oe`, so no two agents ever drive the pads in the same cycle.
- At least one parked cycle (`uio_oe`=0) always separates consecutive owners.

## Interface
- `NREQ`, 4: number of requesters; must be ≥2.
- `MAX_HOLD`, 8: maximum consecutive OWN cycles per grant; must be ≥1.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `ena`  in  1: design enable; when low, no grants are issued.
- `req`  in  NREQ: per-requester bus request, level-sensitive.
- `dir`  in  NREQ: per-requester mode; 1 = drive pads, 0 = sample pads.
- `wdata`  in  NREQ*8: packed drive data; requester i uses bits [8i+7:8i].
- `uio_in`  in  8: pad input path.
- `uio_out`  out  8: pad output path.
- `uio_oe`  out  8: pad output enables; 1 = drive.
- `gnt`  out  NREQ: one-hot grant, or all zero.
- `rdata`  out  8: registered pad sample.
- `rvalid`  out  1: `rdata` was captured for the current owner in the previous cycle.
- `busy`  out  1: high in OWN or TURN.

## Operation
- FSM states: IDLE, OWN, TURN. State, owner index, latched direction `odir`, round-robin pointer `ptr` and hold counter `hcnt` are registers.
- Arbitration happens only in IDLE and TURN with `ena`=1.
  - Search `req` starting at `(ptr+1) mod NREQ` and ascending with wrap; the first set bit wins.
  - Winner → OWN. `owner` and `ptr` are set to the winner, `odir` is set to `dir[winner]`, `hcnt` is set to 1.
  - No request → IDLE.
- OWN:
  - `gnt` = one-hot(`owner`).
  - `hcnt` increments each cycle and saturates.
  - Leave OWN when `req[owner]`=0 or `hcnt`==`MAX_HOLD`; next state is TURN. The exit cycle still shows `gnt`.
- TURN lasts exactly one cycle: `gnt`=0, `uio_oe`=0, then arbitration.
- `ena`=0 in any state forces IDLE next cycle with `gnt`=0. No grant is issued while `ena` is low.
- Pad drive (combinational from registered state and owner):
  - State OWN and `odir`=1: `uio_oe`=8'hFF and `uio_out`=`wdata[owner]`, with live data.
  - All other cases: `uio_oe`=8'h00 and `uio_out`=8'h00.
- `dir` is latched at grant. Later changes to `dir[owner]` are ignored until the next grant, so the bus cannot flip mid-grant.
- Read path:
  - In OWN with `odir`=0, `rdata` ← `uio_in` and `rvalid` ← 1.
  - Otherwise `rvalid` ← 0 and `rdata` holds its value.
- Requests from non-owners during OWN are ignored until the next arbitration point.
- If the owner is the only requester when its hold expires, it passes through TURN and is re-granted.

## Timing
- Reset values:
  - State IDLE, `gnt`=0, `uio_oe`=0, `uio_out`=0, `rdata`=0, `rvalid`=0, `busy`=0.
  - `ptr`=NREQ-1, so requester 0 has first priority.
  - `hcnt`=0.
- `rst` wins over every other input. Reset during OWN releases the pads on the next edge.
- Latency from `req` sampled high in IDLE to `gnt` high: 1 cycle.
- Owner handover: OWN(last) → TURN → OWN(new). There is always exactly one idle bus cycle.
- A grant lasts at most `MAX_HOLD` cycles. With `req` held, it lasts exactly `MAX_HOLD` cycles.
- `rvalid`/`rdata` lag the sampled `uio_in` by 1 cycle. The final `rvalid` pulse occurs in the first cycle after OWN.
- `hcnt` width is clog2(MAX_HOLD+1). `ptr` and `owner` width is clog2(NREQ). Both wrap modulo NREQ.

## Test plan
- Reset: hold `rst` for 2 cycles with random inputs. Required: all outputs 0 and `busy`=0. After release, `req`=4'b1111 grants requester 0 first.
- Single write: `req[1]`=1, `dir[1]`=1, `wdata[1]`=8'hA5, held for 12 cycles. Required:
  - `gnt`=4'b0010 one cycle later, with `uio_oe`=FF and `uio_out`=A5.
  - `gnt` holds for exactly 8 cycles, then 1 TURN cycle with `oe`=00, then re-grant to requester 1.
- Round-robin: `req[0]` and `req[2]` both high, each owner drops `req` after 3 granted cycles and reasserts 1 cycle later. Required grant sequence: 0, TURN, 2, TURN, 0, with `gnt` never multi-hot.
- Read: `req[3]`=1, `dir[3]`=0, `uio_in`=8'h3C then 8'hC3 for 2 owned cycles. Required:
  - `uio_oe`=00 throughout.
  - `rvalid`=1 with `rdata`=3C, then C3, each one cycle later.
  - `rvalid`=0 afterwards, with `rdata` holding C3.
- Mid-grant disturbances:
  - Toggling `dir[1]` to 0 while requester 1 drives: `oe` stays FF.
  - Dropping `ena`: next cycle `gnt`=0, `oe`=00, IDLE, and no grant until `ena` returns.
- Reset mid-OWN while driving: next cycle `uio_oe`=00 and `gnt`=0. `ptr` is restored, so with `req`=4'b0101 requester 0 wins.
